// File: rtl/player_ship_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : player_ship_multi_if
// Purpose  : Bundles the game-facing signals of player_ship_multi: operating
//            mode, buttons, VGA pixel position, alien / alien-laser positions,
//            barrier feedback, and the ship / laser drawing and status outputs.
// Ports    : master - driver side (game top / testbench)
//            slave  - player_ship_multi side
// Revision : 1.0 - initial release
// ============================================================================
interface player_ship_multi_if #(
  parameter int NUM_LASERS       = 3,
  parameter int NUM_ALIENS       = 3,
  parameter int NUM_ALIEN_LASERS = 3
);
  // control and pixel position
  logic                            mode;
  logic                            button_left;
  logic                            button_right;
  logic                            button_shoot;
  logic [9:0]                      xCoord;
  logic [9:0]                      yCoord;
  // other game objects (packed, object i at [10i+9:10i])
  logic [10*NUM_ALIENS-1:0]        alien_xCoord;
  logic [10*NUM_ALIENS-1:0]        alien_yCoord;
  logic [10*NUM_ALIEN_LASERS-1:0]  alien_laser_xCoord;
  logic [10*NUM_ALIEN_LASERS-1:0]  alien_laser_yCoord;
  logic [NUM_LASERS-1:0]           barr_laser_hit;
  // drawing and status
  logic [7:0]                      rgb;
  logic [7:0]                      rgb_spaceship_laser;
  logic                            is_spaceship;
  logic                            is_spaceship_laser;
  logic [10*NUM_LASERS-1:0]        laser_xCoord;
  logic [10*NUM_LASERS-1:0]        laser_yCoord;
  logic [NUM_LASERS-1:0]           laser_active;
  logic [NUM_ALIENS-1:0]           alien_hit;
  logic [2:0]                      lives_left;
  logic                            game_over;

  modport master (
    output mode, button_left, button_right, button_shoot, xCoord, yCoord,
           alien_xCoord, alien_yCoord, alien_laser_xCoord, alien_laser_yCoord,
           barr_laser_hit,
    input  rgb, rgb_spaceship_laser, is_spaceship, is_spaceship_laser,
           laser_xCoord, laser_yCoord, laser_active, alien_hit, lives_left,
           game_over
  );

  modport slave (
    input  mode, button_left, button_right, button_shoot, xCoord, yCoord,
           alien_xCoord, alien_yCoord, alien_laser_xCoord, alien_laser_yCoord,
           barr_laser_hit,
    output rgb, rgb_spaceship_laser, is_spaceship, is_spaceship_laser,
           laser_xCoord, laser_yCoord, laser_active, alien_hit, lives_left,
           game_over
  );
endinterface
`default_nettype wire

// File: rtl/player_ship_multi.sv
`default_nettype none
// ============================================================================
// Module   : player_ship_multi
// Purpose  : Player spaceship for the VGA space-invaders game with a pool of
//            NUM_LASERS concurrent lasers, laser/alien and alien-laser/ship
//            collision, and an ALIVE / RESPAWN / DEAD lives state machine.
//            All game motion advances once per frame (pixel 0,0).
// Ports    : clk     - pixel clock
//            restart - asynchronous active-high reset
//            bus     - player_ship_multi_if.slave (mode, buttons, pixel
//                      position, alien data in; drawing/status out)
// Revision : 1.0 - initial release
// ============================================================================
module player_ship_multi #(
  parameter int NUM_LASERS       = 3,
  parameter int NUM_ALIENS       = 3,
  parameter int NUM_ALIEN_LASERS = 3,
  parameter int LIVES            = 3,
  parameter int MOVE_STEP        = 1,
  parameter int LASER_STEP       = 2,
  parameter int COOLDOWN_FRAMES  = 15,
  parameter int RESPAWN_FRAMES   = 60
) (
  input  logic               clk,
  input  logic               restart,
  player_ship_multi_if.slave bus
);

  localparam int CD_W = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam int RS_W = (RESPAWN_FRAMES  < 1) ? 1 : $clog2(RESPAWN_FRAMES + 1);

  localparam logic [9:0]      SHIP_X_HOME  = 10'd320;
  localparam logic [9:0]      SHIP_X_MIN   = 10'd20;
  localparam logic [9:0]      SHIP_X_MAX   = 10'd620;
  localparam logic [9:0]      SHIP_HALF_W  = 10'd20;
  localparam logic [9:0]      SHIP_Y_TOP   = 10'd420;
  localparam logic [9:0]      SHIP_Y_BOT   = 10'd430;
  localparam logic [9:0]      SHIP_HIT_Y   = 10'd415;
  localparam logic [9:0]      LASER_PARK_Y = 10'd417;
  localparam logic [9:0]      ALIEN_HALF_W = 10'd15;
  localparam logic [9:0]      MOVE_INC     = 10'(MOVE_STEP);
  localparam logic [9:0]      LASER_INC    = 10'(LASER_STEP);
  // Laser tip reaches the top border / an alien's lower edge within one step.
  localparam logic [9:0]      TOP_RETIRE_Y = 10'(60 + 5 + LASER_STEP);
  localparam logic [10:0]     ALIEN_REACH  = 11'(8 + LASER_STEP);
  localparam logic [2:0]      LIVES_INIT   = 3'(LIVES);
  localparam logic [CD_W-1:0] CD_LOAD      = CD_W'(COOLDOWN_FRAMES);
  localparam logic [RS_W-1:0] RS_LOAD      = RS_W'(RESPAWN_FRAMES);

  typedef enum logic [1:0] {
    ST_ALIVE   = 2'd0,
    ST_RESPAWN = 2'd1,
    ST_DEAD    = 2'd2
  } state_t;

  // |a - b| <= r evaluated in 11 bits so neither side can wrap.
  function automatic logic near(input logic [9:0] a, input logic [9:0] b,
                                input logic [9:0] r);
    logic [10:0] ae, be, re;
    ae   = {1'b0, a};
    be   = {1'b0, b};
    re   = {1'b0, r};
    near = (ae + re >= be) && (ae <= be + re);
  endfunction

  // registered state
  state_t                state, state_nxt;
  logic [9:0]            ship_x, ship_x_nxt;
  logic [2:0]            lives, lives_nxt;
  logic [CD_W-1:0]       cooldown, cooldown_nxt;
  logic [RS_W-1:0]       respawn_cnt, respawn_nxt;
  logic                  shoot_prev, shoot_prev_nxt;
  logic [9:0]            laser_x [NUM_LASERS];
  logic [9:0]            laser_y [NUM_LASERS];
  logic [9:0]            lx_nxt  [NUM_LASERS];
  logic [9:0]            ly_nxt  [NUM_LASERS];
  logic [NUM_LASERS-1:0] laser_active, active_nxt;
  logic [NUM_ALIENS-1:0] alien_hit, alien_hit_nxt;

  // combinational helpers
  logic                  frame_tick;
  logic [NUM_LASERS-1:0] retire;
  logic                  ship_struck;
  logic                  launch_done;
  logic                  laser_pixel;

  assign frame_tick = (bus.xCoord == 10'd0) && (bus.yCoord == 10'd0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      state        <= ST_ALIVE;
      ship_x       <= SHIP_X_HOME;
      lives        <= LIVES_INIT;
      cooldown     <= '0;
      respawn_cnt  <= '0;
      shoot_prev   <= 1'b0;
      laser_active <= '0;
      alien_hit    <= '0;
      for (int k = 0; k < NUM_LASERS; k++) begin
        laser_x[k] <= SHIP_X_HOME;
        laser_y[k] <= LASER_PARK_Y;
      end
    end else begin
      state        <= state_nxt;
      ship_x       <= ship_x_nxt;
      lives        <= lives_nxt;
      cooldown     <= cooldown_nxt;
      respawn_cnt  <= respawn_nxt;
      shoot_prev   <= shoot_prev_nxt;
      laser_active <= active_nxt;
      alien_hit    <= alien_hit_nxt;
      for (int k = 0; k < NUM_LASERS; k++) begin
        laser_x[k] <= lx_nxt[k];
        laser_y[k] <= ly_nxt[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    ship_x_nxt     = ship_x;
    lives_nxt      = lives;
    cooldown_nxt   = cooldown;
    respawn_nxt    = respawn_cnt;
    shoot_prev_nxt = shoot_prev;
    active_nxt     = laser_active;
    alien_hit_nxt  = '0;
    retire         = '0;
    ship_struck    = 1'b0;
    launch_done    = 1'b0;
    for (int k = 0; k < NUM_LASERS; k++) begin
      lx_nxt[k] = laser_x[k];
      ly_nxt[k] = laser_y[k];
    end

    if (frame_tick) begin
      shoot_prev_nxt = bus.button_shoot;
      if (cooldown != '0) begin
        cooldown_nxt = cooldown - 1'b1;
      end

      // Laser flight; barrier hits are handled below and win over flight.
      if (state != ST_DEAD) begin
        for (int k = 0; k < NUM_LASERS; k++) begin
          if (laser_active[k] && !bus.barr_laser_hit[k]) begin
            if (laser_y[k] <= TOP_RETIRE_Y) begin
              retire[k] = 1'b1;
            end
            for (int i = 0; i < NUM_ALIENS; i++) begin
              if (({1'b0, laser_y[k]} <= {1'b0, bus.alien_yCoord[10*i +: 10]} + ALIEN_REACH) &&
                  near(laser_x[k], bus.alien_xCoord[10*i +: 10], ALIEN_HALF_W)) begin
                retire[k]        = 1'b1;
                alien_hit_nxt[i] = 1'b1;
              end
            end
            if (retire[k]) begin
              active_nxt[k] = 1'b0;
              lx_nxt[k]     = ship_x;
              ly_nxt[k]     = LASER_PARK_Y;
            end else begin
              ly_nxt[k] = laser_y[k] - LASER_INC;
            end
          end
        end
      end

      case (state)
        ST_ALIVE: begin
          for (int j = 0; j < NUM_ALIEN_LASERS; j++) begin
            if ((bus.alien_laser_yCoord[10*j +: 10] >= SHIP_HIT_Y) &&
                near(bus.alien_laser_xCoord[10*j +: 10], ship_x, SHIP_HALF_W)) begin
              ship_struck = 1'b1;
            end
          end

          if (ship_struck) begin
            lives_nxt = lives - 3'd1;
            if (lives <= 3'd1) begin
              state_nxt = ST_DEAD;
            end else begin
              state_nxt   = ST_RESPAWN;
              respawn_nxt = RS_LOAD;
            end
          end else begin
            if (bus.button_left && !bus.button_right && (ship_x > SHIP_X_MIN)) begin
              ship_x_nxt = (ship_x >= SHIP_X_MIN + MOVE_INC) ? ship_x - MOVE_INC : SHIP_X_MIN;
            end else if (bus.button_right && !bus.button_left && (ship_x < SHIP_X_MAX)) begin
              ship_x_nxt = (ship_x + MOVE_INC <= SHIP_X_MAX) ? ship_x + MOVE_INC : SHIP_X_MAX;
            end

            // Launch into the lowest-index free slot; a press with no free
            // slot is simply lost.
            if (bus.button_shoot && !shoot_prev && (cooldown == '0)) begin
              for (int k = 0; k < NUM_LASERS; k++) begin
                if (!laser_active[k] && !launch_done) begin
                  launch_done   = 1'b1;
                  active_nxt[k] = 1'b1;
                  lx_nxt[k]     = ship_x;
                  ly_nxt[k]     = LASER_PARK_Y;
                end
              end
              if (launch_done) begin
                cooldown_nxt = CD_LOAD;
              end
            end
          end
        end

        ST_RESPAWN: begin
          if (respawn_cnt <= RS_W'(1)) begin
            state_nxt  = ST_ALIVE;
            ship_x_nxt = SHIP_X_HOME;
          end else begin
            respawn_nxt = respawn_cnt - 1'b1;
          end
        end

        default: begin
        end
      endcase
    end

    // Barrier hits act on every clock, not only at frame start.
    for (int k = 0; k < NUM_LASERS; k++) begin
      if (bus.barr_laser_hit[k]) begin
        active_nxt[k] = 1'b0;
        lx_nxt[k]     = ship_x;
        ly_nxt[k]     = LASER_PARK_Y;
      end
    end

    if (state_nxt == ST_DEAD) begin
      active_nxt = '0;
      for (int k = 0; k < NUM_LASERS; k++) begin
        lx_nxt[k] = ship_x;
        ly_nxt[k] = LASER_PARK_Y;
      end
    end

    // Attract mode holds everything at its reset value, overriding all events.
    if (!bus.mode) begin
      state_nxt      = ST_ALIVE;
      ship_x_nxt     = SHIP_X_HOME;
      lives_nxt      = LIVES_INIT;
      cooldown_nxt   = '0;
      respawn_nxt    = '0;
      shoot_prev_nxt = 1'b0;
      active_nxt     = '0;
      alien_hit_nxt  = '0;
      for (int k = 0; k < NUM_LASERS; k++) begin
        lx_nxt[k] = SHIP_X_HOME;
        ly_nxt[k] = LASER_PARK_Y;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pixel generation
  // --------------------------------------------------------------------------
  always_comb begin
    laser_pixel = 1'b0;
    for (int k = 0; k < NUM_LASERS; k++) begin
      if (laser_active[k] && near(laser_x[k], bus.xCoord, 10'd1) &&
          near(laser_y[k], bus.yCoord, 10'd5)) begin
        laser_pixel = 1'b1;
      end
    end
  end

  assign bus.is_spaceship = (state == ST_ALIVE) &&
                            (bus.yCoord >= SHIP_Y_TOP) && (bus.yCoord <= SHIP_Y_BOT) &&
                            near(bus.xCoord, ship_x, SHIP_HALF_W);
  assign bus.is_spaceship_laser  = laser_pixel;
  assign bus.rgb                 = 8'b0111_1000;
  assign bus.rgb_spaceship_laser = 8'hFF;
  assign bus.laser_active        = laser_active;
  assign bus.alien_hit           = alien_hit;
  assign bus.lives_left          = lives;
  assign bus.game_over           = (state == ST_DEAD);

  generate
    for (genvar k = 0; k < NUM_LASERS; k++) begin : g_pack
      assign bus.laser_xCoord[10*k +: 10] = laser_x[k];
      assign bus.laser_yCoord[10*k +: 10] = laser_y[k];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_player_ship_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_ship_multi
// Purpose  : Directed self-checking bench for player_ship_multi: reset,
//            movement limits, firing/cooldown/slot pool, barrier retirement,
//            attract-mode clear, alien hit pulse, lives/respawn/game-over and
//            asynchronous restart mid-respawn.
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_ship_multi;

  logic clk;
  logic restart;
  int   errors = 0;
  int   checks = 0;
  int   center;

  player_ship_multi_if #(.NUM_LASERS(3), .NUM_ALIENS(3), .NUM_ALIEN_LASERS(3)) bus ();

  player_ship_multi dut (
    .clk     (clk),
    .restart (restart),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One frame: frame_tick for exactly one clock, then a neutral pixel.
  task automatic frame();
    @(negedge clk);
    bus.xCoord = 10'd0;
    bus.yCoord = 10'd0;
    @(negedge clk);
    bus.xCoord = 10'd1;
    bus.yCoord = 10'd500;
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic shoot_pulse();
    bus.button_shoot = 1'b1;
    frame();
    bus.button_shoot = 1'b0;
    frame();
  endtask

  // Scan a ship row and return the midpoint of the drawn span, -1 if hidden.
  task automatic measure_ship(output int c);
    int lo, hi;
    lo = -1;
    hi = -1;
    bus.yCoord = 10'd425;
    for (int x = 0; x <= 700; x++) begin
      bus.xCoord = 10'(x);
      #1;
      if (bus.is_spaceship) begin
        if (lo < 0) lo = x;
        hi = x;
      end
    end
    bus.xCoord = 10'd1;
    bus.yCoord = 10'd500;
    c = (lo < 0) ? -1 : (lo + hi) / 2;
  endtask

  task automatic alien_laser_strike();
    bus.alien_laser_xCoord[9:0] = 10'd330;
    bus.alien_laser_yCoord[9:0] = 10'd416;
    frame();
    bus.alien_laser_xCoord[9:0] = 10'd900;
    bus.alien_laser_yCoord[9:0] = 10'd0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    checks++;
    if (bus.laser_active !== 3'b000) begin
      errors++; $display("FAIL reset_laser_active: got %b want 000", bus.laser_active);
    end
    checks++;
    if (bus.lives_left !== 3'd3 || bus.game_over !== 1'b0) begin
      errors++; $display("FAIL reset_lives: got lives=%0d go=%b want 3/0", bus.lives_left, bus.game_over);
    end
    checks++;
    if (bus.alien_hit !== 3'b000) begin
      errors++; $display("FAIL reset_alien_hit: got %b want 000", bus.alien_hit);
    end
    checks++;
    if (bus.rgb !== 8'h78 || bus.rgb_spaceship_laser !== 8'hFF) begin
      errors++; $display("FAIL reset_rgb: got %h/%h want 78/ff", bus.rgb, bus.rgb_spaceship_laser);
    end
    @(negedge clk);
    restart = 1'b0;
    measure_ship(center);
    checks++;
    if (center != 320) begin
      errors++; $display("FAIL reset_ship_x: got %0d want 320", center);
    end
    checks++;
    if (bus.laser_xCoord[9:0] !== 10'd320 || bus.laser_yCoord[9:0] !== 10'd417) begin
      errors++; $display("FAIL reset_laser_park: got (%0d,%0d) want (320,417)",
                         bus.laser_xCoord[9:0], bus.laser_yCoord[9:0]);
    end
  endtask

  task automatic test_movement();
    bus.button_right = 1'b1;
    frames(310);
    bus.button_right = 1'b0;
    measure_ship(center);
    checks++;
    if (center != 620) begin
      errors++; $display("FAIL move_right_limit: got %0d want 620", center);
    end
    bus.button_left = 1'b1;
    frames(700);
    measure_ship(center);
    checks++;
    if (center != 20) begin
      errors++; $display("FAIL move_left_limit: got %0d want 20", center);
    end
    bus.button_right = 1'b1;
    frames(10);
    bus.button_left = 1'b0;
    bus.button_right = 1'b0;
    measure_ship(center);
    checks++;
    if (center != 20) begin
      errors++; $display("FAIL move_both_pressed: got %0d want 20", center);
    end
    bus.button_right = 1'b1;
    frames(300);
    bus.button_right = 1'b0;
    measure_ship(center);
    checks++;
    if (center != 320) begin
      errors++; $display("FAIL move_return: got %0d want 320", center);
    end
  endtask

  // Launch ticks: N (slot0), N+5 (cooldown), N+20 (slot1), N+40 (slot2), N+60 (full).
  task automatic test_firing();
    bus.button_shoot = 1'b1;
    frame();
    bus.button_shoot = 1'b0;
    checks++;
    if (bus.laser_active !== 3'b001 || bus.laser_xCoord[9:0] !== 10'd320 ||
        bus.laser_yCoord[9:0] !== 10'd417) begin
      errors++; $display("FAIL fire_first: got act=%b (%0d,%0d) want 001 (320,417)",
                         bus.laser_active, bus.laser_xCoord[9:0], bus.laser_yCoord[9:0]);
    end
    frame();
    frames(3);
    shoot_pulse();
    checks++;
    if (bus.laser_active !== 3'b001) begin
      errors++; $display("FAIL fire_cooldown: got %b want 001", bus.laser_active);
    end
    frames(13);
    shoot_pulse();
    checks++;
    if (bus.laser_active !== 3'b011) begin
      errors++; $display("FAIL fire_second: got %b want 011", bus.laser_active);
    end
    frames(18);
    shoot_pulse();
    checks++;
    if (bus.laser_active !== 3'b111) begin
      errors++; $display("FAIL fire_third: got %b want 111", bus.laser_active);
    end
    frames(18);
    shoot_pulse();
    checks++;
    if (bus.laser_active !== 3'b111) begin
      errors++; $display("FAIL fire_no_slot: got %b want 111", bus.laser_active);
    end
    checks++;
    if (bus.laser_yCoord[9:0] !== 10'd295 || bus.laser_yCoord[19:10] !== 10'd335 ||
        bus.laser_yCoord[29:20] !== 10'd375) begin
      errors++; $display("FAIL fire_flight_y: got %0d/%0d/%0d want 295/335/375",
                         bus.laser_yCoord[9:0], bus.laser_yCoord[19:10], bus.laser_yCoord[29:20]);
    end
  endtask

  task automatic test_barrier();
    bus.button_right = 1'b1;
    frames(5);
    bus.button_right = 1'b0;
    bus.barr_laser_hit = 3'b010;
    @(negedge clk);
    bus.barr_laser_hit = 3'b000;
    checks++;
    if (bus.laser_active !== 3'b101 || bus.laser_xCoord[19:10] !== 10'd325 ||
        bus.laser_yCoord[19:10] !== 10'd417) begin
      errors++; $display("FAIL barrier_retire: got act=%b (%0d,%0d) want 101 (325,417)",
                         bus.laser_active, bus.laser_xCoord[19:10], bus.laser_yCoord[19:10]);
    end
  endtask

  task automatic test_mode_clear();
    bus.button_right = 1'b1;
    @(negedge clk);
    bus.mode   = 1'b0;
    bus.xCoord = 10'd0;
    bus.yCoord = 10'd0;
    @(negedge clk);
    bus.mode = 1'b1;
    bus.xCoord = 10'd1;
    bus.yCoord = 10'd500;
    bus.button_right = 1'b0;
    checks++;
    if (bus.laser_active !== 3'b000 || bus.laser_xCoord[9:0] !== 10'd320) begin
      errors++; $display("FAIL mode_clear_lasers: got act=%b x0=%0d want 000 320",
                         bus.laser_active, bus.laser_xCoord[9:0]);
    end
    measure_ship(center);
    checks++;
    if (center != 320) begin
      errors++; $display("FAIL mode_clear_ship: got %0d want 320", center);
    end
  endtask

  // Laser from y=417 steps 2/frame; at y=109 (154 moves) it is within alien reach 110.
  task automatic test_alien_hit();
    bit early;
    early = 1'b0;
    bus.alien_xCoord[19:10] = 10'd320;
    bus.alien_yCoord[19:10] = 10'd100;
    bus.button_shoot = 1'b1;
    frame();
    bus.button_shoot = 1'b0;
    for (int f = 0; f < 154; f++) begin
      frame();
      if (bus.alien_hit !== 3'b000 || bus.laser_active[0] !== 1'b1) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0 || bus.laser_yCoord[9:0] !== 10'd109) begin
      errors++; $display("FAIL alien_approach: got early=%b y=%0d want 0 109",
                         early, bus.laser_yCoord[9:0]);
    end
    frame();
    checks++;
    if (bus.alien_hit !== 3'b010) begin
      errors++; $display("FAIL alien_hit_pulse: got %b want 010", bus.alien_hit);
    end
    checks++;
    if (bus.laser_active !== 3'b000 || bus.laser_yCoord[9:0] !== 10'd417) begin
      errors++; $display("FAIL alien_hit_retire: got act=%b y=%0d want 000 417",
                         bus.laser_active, bus.laser_yCoord[9:0]);
    end
    @(negedge clk);
    checks++;
    if (bus.alien_hit !== 3'b000) begin
      errors++; $display("FAIL alien_hit_width: got %b want 000", bus.alien_hit);
    end
    bus.alien_xCoord[19:10] = 10'd900;
    bus.alien_yCoord[19:10] = 10'd0;
  endtask

  task automatic test_ship_hit();
    alien_laser_strike();
    checks++;
    if (bus.lives_left !== 3'd2) begin
      errors++; $display("FAIL hit1_lives: got %0d want 2", bus.lives_left);
    end
    measure_ship(center);
    checks++;
    if (center != -1) begin
      errors++; $display("FAIL hit1_hidden: got %0d want -1", center);
    end
    frames(59);
    measure_ship(center);
    checks++;
    if (center != -1) begin
      errors++; $display("FAIL respawn_still_hidden: got %0d want -1", center);
    end
    frame();
    measure_ship(center);
    checks++;
    if (center != 320) begin
      errors++; $display("FAIL respawn_reappear: got %0d want 320", center);
    end
    alien_laser_strike();
    frames(60);
    measure_ship(center);
    checks++;
    if (bus.lives_left !== 3'd1 || center != 320) begin
      errors++; $display("FAIL hit2: got lives=%0d ship=%0d want 1 320", bus.lives_left, center);
    end
    shoot_pulse();
    checks++;
    if (bus.laser_active !== 3'b001) begin
      errors++; $display("FAIL fire_before_death: got %b want 001", bus.laser_active);
    end
    alien_laser_strike();
    checks++;
    if (bus.lives_left !== 3'd0 || bus.game_over !== 1'b1 || bus.laser_active !== 3'b000) begin
      errors++; $display("FAIL hit3_dead: got lives=%0d go=%b act=%b want 0 1 000",
                         bus.lives_left, bus.game_over, bus.laser_active);
    end
    bus.button_right = 1'b1;
    frames(5);
    bus.button_right = 1'b0;
    shoot_pulse();
    measure_ship(center);
    checks++;
    if (bus.game_over !== 1'b1 || bus.laser_active !== 3'b000 || center != -1) begin
      errors++; $display("FAIL dead_sticky: got go=%b act=%b ship=%0d want 1 000 -1",
                         bus.game_over, bus.laser_active, center);
    end
  endtask

  task automatic test_restart_respawn();
    @(negedge clk);
    #2 restart = 1'b1;
    #1;
    checks++;
    if (bus.game_over !== 1'b0 || bus.lives_left !== 3'd3) begin
      errors++; $display("FAIL restart_from_dead: got go=%b lives=%0d want 0 3",
                         bus.game_over, bus.lives_left);
    end
    @(negedge clk);
    restart = 1'b0;
    shoot_pulse();
    frames(18);
    shoot_pulse();
    alien_laser_strike();
    frames(3);
    checks++;
    if (bus.lives_left !== 3'd2 || bus.laser_active !== 3'b011 ||
        bus.laser_yCoord[9:0] !== 10'd367 || bus.laser_yCoord[19:10] !== 10'd407) begin
      errors++; $display("FAIL respawn_flight: got lives=%0d act=%b y=%0d/%0d want 2 011 367/407",
                         bus.lives_left, bus.laser_active, bus.laser_yCoord[9:0], bus.laser_yCoord[19:10]);
    end
    @(negedge clk);
    #2 restart = 1'b1;
    #1;
    checks++;
    if (bus.laser_active !== 3'b000 || bus.lives_left !== 3'd3) begin
      errors++; $display("FAIL restart_async: got act=%b lives=%0d want 000 3",
                         bus.laser_active, bus.lives_left);
    end
    measure_ship(center);
    checks++;
    if (center != 320) begin
      errors++; $display("FAIL restart_alive: got %0d want 320", center);
    end
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    restart                = 1'b1;
    bus.mode               = 1'b1;
    bus.button_left        = 1'b0;
    bus.button_right       = 1'b0;
    bus.button_shoot       = 1'b0;
    bus.xCoord             = 10'd1;
    bus.yCoord             = 10'd500;
    bus.alien_xCoord       = {3{10'd900}};
    bus.alien_yCoord       = {3{10'd0}};
    bus.alien_laser_xCoord = {3{10'd900}};
    bus.alien_laser_yCoord = {3{10'd0}};
    bus.barr_laser_hit     = 3'b000;

    test_reset();
    test_movement();
    test_firing();
    test_barrier();
    test_mode_clear();
    test_alien_hit();
    test_ship_hit();
    test_restart_respawn();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/player_ship_multi.md
# player_ship_multi

Parametrised successor to the single-shot player spaceship for the VGA space-invaders game. Handles ship movement, a pool of `NUM_LASERS` concurrent player lasers, collision against `NUM_ALIENS` aliens and `NUM_ALIEN_LASERS` alien lasers, and a lives/respawn state machine. It sits beside the alien, barrier and scoreboard blocks, driven by the VGA pixel counters and board buttons.

## Interface
- NUM_LASERS, 3: concurrent player laser slots (1..8)
- NUM_ALIENS, 3: alien positions checked for laser hits
- NUM_ALIEN_LASERS, 3: alien lasers checked against the ship
- LIVES, 3: starting lives (1..7)
- MOVE_STEP, 1: ship pixels per frame
- LASER_STEP, 2: laser pixels per frame (upward)
- COOLDOWN_FRAMES, 15: minimum frames between launches
- RESPAWN_FRAMES, 60: hidden frames after a non-fatal hit
- clk  in  1  pixel clock
- restart  in  1  asynchronous active-high reset
- mode  in  1  0 = attract/menu (synchronous clear to reset state), 1 = play
- button_left, button_right, button_shoot  in  1 each  debounced buttons, level
- xCoord, yCoord  in  10 each  current VGA pixel
- alien_xCoord, alien_yCoord  in  10*NUM_ALIENS each  packed centres, alien i at [10i+9:10i]
- alien_laser_xCoord, alien_laser_yCoord  in  10*NUM_ALIEN_LASERS each  packed centres
- barr_laser_hit  in  NUM_LASERS  per-slot barrier hit, level
- rgb, rgb_spaceship_laser  out  8 each  ship colour 8'b01111000, laser colour 8'hFF
- is_spaceship, is_spaceship_laser  out  1 each  pixel inside ship / inside any active laser
- laser_xCoord, laser_yCoord  out  10*NUM_LASERS each  packed slot centres
- laser_active  out  NUM_LASERS  slot in flight
- alien_hit  out  NUM_ALIENS  one-clk pulse, alien i struck
- lives_left  out  3  remaining lives
- game_over  out  1  lives exhausted

## Operation
- frame_tick = (xCoord==0 && yCoord==0); all motion, firing, collision and counters update only on frame_tick.
- States: ALIVE, RESPAWN, DEAD. Reset/mode==0 -> ALIVE, ship_x=320, lives=LIVES, all slots inactive at (320,417), cooldown=0, game_over=0.
- Movement (ALIVE only): left alone and ship_x > 20 -> ship_x -= MOVE_STEP; right alone and ship_x < 620 -> += MOVE_STEP; both pressed -> no move.
- Firing (ALIVE only): rising edge of button_shoot sampled frame-to-frame, cooldown==0, and at least one free slot -> lowest-index free slot set active at (ship_x,417), cooldown=COOLDOWN_FRAMES. No free slot -> press discarded. Cooldown decrements to 0 each tick.
- Laser flight (any state except DEAD): active slot retires (inactive, reparked at (ship_x,417)) if y <= 60+5+LASER_STEP, or for any alien i: y <= alien_y+8+LASER_STEP and alien_x-15 <= x <= alien_x+15; otherwise y -= LASER_STEP. Each retiring alien hit sets alien_hit[i]; several slots may retire on one alien in one tick, alien_hit[i] pulses once.
- barr_laser_hit[k]: slot k retires on any clk, not only frame_tick; takes priority over flight update.
- Ship hit (ALIVE only): any alien laser with y >= 415 and ship_x-20 <= x <= ship_x+20. lives -= 1; lives==0 -> DEAD, else RESPAWN with counter=RESPAWN_FRAMES.
- RESPAWN: ship hidden, no movement/firing, in-flight lasers continue; counter reaches 0 -> ship_x=320, ALIVE. Alien-laser overlap ignored.
- DEAD: game_over=1, ship hidden, all slots cleared; leaves only via restart or mode==0.
- is_spaceship = state==ALIVE and 420<=yCoord<=430 and ship_x-20<=xCoord<=ship_x+20. is_spaceship_laser = OR over active slots of |x-xCoord|<=1 and |y-yCoord|<=5, inclusive.
- All comparisons unsigned 10-bit; subtractions guarded so no wrap (ship_x >= 20, laser y >= 65 while active).

## Timing
- restart asserts -> all registers at reset values immediately; outputs: alien_hit=0, laser_active=0, lives_left=LIVES, game_over=0, rgb constants.
- State, positions, lives updated on the clk edge where frame_tick is high; visible from the next clk.
- alien_hit high exactly one clk (the frame_tick edge + 1 register stage).
- barr_laser_hit retirement: laser_active[k] low one clk after assertion.
- Launch latency: press observed on tick N -> slot active after tick N, first move on tick N+1.
- mode==0 overrides every event in the same clk.

## Test plan
- Reset, hold right 300 frames -> ship_x stops at 620; hold left 700 frames -> stops at 20; both held -> unchanged.
- Four shoot pulses 20 frames apart, NUM_LASERS=3, lasers unobstructed -> slots 0,1,2 active, fourth discarded; pulse 5 frames after a launch -> discarded by cooldown.
- Alien 1 at (320,100), fire from 320 -> slot retires when y <= 110, alien_hit=3'b010 for one clk, other bits 0.
- Alien laser at (330,416) on ALIVE ship at 320 -> lives 3->2, ship hidden 60 frames, reappears at 320; repeat twice -> game_over=1, laser_active=0.
- barr_laser_hit[1] asserted mid-frame -> laser_active[1]=0 next clk, slot reparked at (ship_x,417).
- restart pulsed mid-RESPAWN with two lasers in flight -> ALIVE, lives=3, laser_active=0 without waiting for a clk edge.
